// File: rtl/fb_pkg.sv
// Shared constants for the frame-buffer write path: byte-mask encodings,
// arbiter FSM states and default frame geometry.
package fb_pkg;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_ADDR_W = 19;

  localparam logic [31:0] MASK_BYTE = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK_HALF = 32'hFFFF_FFFC;
  localparam logic [31:0] MASK_WORD = 32'hFFFF_FFF0;

  // DRAIN covers the cycle the last fill write sits on the port, so done follows it
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle of CPU store, fill-engine control and frame-buffer write port signals.
// slave = arbiter side, master = CPU/fill/frame-buffer environment side.
interface fb_write_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_data;
  logic [31:0]       cpu_mask;
  logic              cpu_ack;

  logic              fill_start;
  logic [9:0]        fill_x0, fill_x1, fill_y0, fill_y1;
  logic [7:0]        fill_color;
  logic              fill_busy, fill_done, fill_err;

  logic              fb_w_en;
  logic [ADDR_W-1:0] fb_address;
  logic [31:0]       fb_game_data;
  logic [31:0]       fb_byte_mask;

  modport slave (
    input  cpu_req, cpu_addr, cpu_data, cpu_mask,
    input  fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    output cpu_ack, fill_busy, fill_done, fill_err,
    output fb_w_en, fb_address, fb_game_data, fb_byte_mask
  );

  modport master (
    output cpu_req, cpu_addr, cpu_data, cpu_mask,
    output fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    input  cpu_ack, fill_busy, fill_done, fill_err,
    input  fb_w_en, fb_address, fb_game_data, fb_byte_mask
  );
endinterface

// File: rtl/fb_fill_walker.sv
// Rectangle raster walker: latches the rect/colour, presents the current fill beat.
// FB_FILL_WORD_EN: aligned 4-pixel runs go out as one word write.
module fb_fill_walker
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int ADDR_W = FB_ADDR_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [9:0]        x0,
  input  logic [9:0]        x1,
  input  logic [9:0]        y0,
  input  logic [9:0]        y1,
  input  logic [7:0]        color,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data,
  output logic [31:0]       mask,
  output logic              last
);
  logic [9:0]        x, x_lo, x_hi, y, y_hi;
  logic [7:0]        col;
  logic [ADDR_W-1:0] row_base;
  logic              word, row_end;

`ifdef FB_FILL_WORD_EN
  assign word = (x[1:0] == 2'b00) && (({1'b0, x} + 11'd3) <= {1'b0, x_hi});
`else
  assign word = 1'b0;
`endif

  assign row_end = word ? (({1'b0, x} + 11'd3) == {1'b0, x_hi}) : (x == x_hi);
  assign last    = row_end && (y == y_hi);
  assign addr    = row_base + ADDR_W'(x);
  assign data    = word ? {4{col}} : {24'h0, col};
  assign mask    = word ? MASK_WORD : MASK_BYTE;

  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      y        <= '0;
      y_hi     <= '0;
      col      <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= x0;
      x_lo     <= x0;
      x_hi     <= x1;
      y        <= y0;
      y_hi     <= y1;
      col      <= color;
      // constant-width product, reduces to shift/add; stepping below is add-only
      row_base <= ADDR_W'(y0) * ADDR_W'(WIDTH);
    end else if (adv) begin
      if (row_end) begin
        x        <= x_lo;
        y        <= y + 10'd1;
        row_base <= row_base + ADDR_W'(WIDTH);
      end else begin
        x <= x + (word ? 10'd4 : 10'd1);
      end
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Single write master for the frame buffer: round-robin merge of CPU stores and
// the rectangle-fill walker into one registered port. Word fill via FB_FILL_WORD_EN.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W
)(
  input  logic                clk,
  input  logic                rst,
  fb_write_arbiter_if.slave   bus
);
  fb_state_e         state;
  logic              rr_cpu;
  logic              rect_ok, start_ok, cpu_vld, fill_vld, gnt_cpu, gnt_fill;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_data, w_mask;
  logic              w_last;

  assign rect_ok  = (bus.fill_x0 <= bus.fill_x1) && (bus.fill_y0 <= bus.fill_y1) &&
                    (32'(bus.fill_x1) < 32'(WIDTH)) && (32'(bus.fill_y1) < 32'(HEIGHT));
  assign start_ok = bus.fill_start && (state == ST_IDLE) && rect_ok;

  // req is still high during its ack cycle; masking it there avoids a double write
  assign cpu_vld  = bus.cpu_req && !bus.cpu_ack;
  assign fill_vld = (state == ST_FILL);
  assign gnt_cpu  = cpu_vld && (!fill_vld || rr_cpu);
  assign gnt_fill = fill_vld && !gnt_cpu;

  fb_fill_walker #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_walker (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .adv   (gnt_fill),
    .x0    (bus.fill_x0),
    .x1    (bus.fill_x1),
    .y0    (bus.fill_y0),
    .y1    (bus.fill_y1),
    .color (bus.fill_color),
    .addr  (w_addr),
    .data  (w_data),
    .mask  (w_mask),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      rr_cpu           <= 1'b1;
      bus.cpu_ack      <= 1'b0;
      bus.fill_busy    <= 1'b0;
      bus.fill_done    <= 1'b0;
      bus.fill_err     <= 1'b0;
      bus.fb_w_en      <= 1'b0;
      bus.fb_address   <= '0;
      bus.fb_game_data <= '0;
      bus.fb_byte_mask <= '0;
    end else begin
      bus.fill_err  <= bus.fill_start && (state == ST_IDLE) && !rect_ok;
      bus.fill_done <= 1'b0;
      case (state)
        ST_IDLE:  if (start_ok) begin
                    state         <= ST_FILL;
                    bus.fill_busy <= 1'b1;
                  end
        ST_FILL:  if (gnt_fill && w_last) state <= ST_DRAIN;
        ST_DRAIN: begin
                    state         <= ST_IDLE;
                    bus.fill_busy <= 1'b0;
                    bus.fill_done <= 1'b1;
                  end
        default:  state <= ST_IDLE;
      endcase

      bus.cpu_ack <= gnt_cpu;
      bus.fb_w_en <= gnt_cpu || gnt_fill;
      if (gnt_cpu) begin
        bus.fb_address   <= bus.cpu_addr;
        bus.fb_game_data <= bus.cpu_data;
        bus.fb_byte_mask <= bus.cpu_mask;
        rr_cpu           <= 1'b0;
      end else if (gnt_fill) begin
        bus.fb_address   <= w_addr;
        bus.fb_game_data <= w_data;
        bus.fb_byte_mask <= w_mask;
        rr_cpu           <= 1'b1;
      end else begin
        bus.fb_address   <= '0;
        bus.fb_game_data <= '0;
        bus.fb_byte_mask <= '0;
      end
    end
  end
endmodule
